// File: rtl/result_mux_rr.sv
// N-channel result selector (fixed select or round-robin) feeding one registered output beat.
// Latency 1 cycle, 1 beat/cycle when out_ready=1; a stalled beat holds and drops every in_ready.
module result_mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_slot_free;
    logic                w_sel_ok;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_gnt;
    logic                w_gnt_vld;
    logic [SEL_W-1:0]    w_gnt;
    logic [WIDTH-1:0]    w_gnt_data;
    logic                w_xfer;
    int                  w_idx;

    assign w_slot_free = !r_out_valid || out_ready;

    // sel can name a non-existent channel when CHANNELS is not a power of two
    always_comb begin
        w_sel_ok = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_ok = 1'b1;
            end
        end
    end

    // Scan downward so the entry closest to rr_ptr is written last and wins
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_gnt = '0;
        w_idx    = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (w_idx == k && in_valid[k]) begin
                    w_rr_vld = 1'b1;
                    w_rr_gnt = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_gnt_vld = w_rr_vld;
            w_gnt     = w_rr_gnt;
        end else begin
            w_gnt_vld = w_sel_ok;
            w_gnt     = sel;
        end
    end

    always_comb begin
        in_ready   = '0;
        w_gnt_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_gnt == SEL_W'(k)) begin
                w_gnt_data = in_data[k*WIDTH +: WIDTH];
                if (rst_n && w_gnt_vld && w_slot_free) begin
                    in_ready[k] = 1'b1;
                end
            end
        end
    end

    assign w_xfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt;
            if (mode) begin
                r_rr_ptr <= (w_gnt == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt + SEL_W'(1);
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_result_mux_rr.sv
// Bench for result_mux_rr: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the selector.
module tb_result_mux_rr;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_chan;
    logic              out_valid;
    logic              out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic          m_vld;
    logic [W-1:0]  m_dat;
    logic [SW-1:0] m_chan;
    int            m_ptr;

    always #5 clk = ~clk;

    result_mux_rr #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Channel the rules would grant this cycle, -1 if none
    function automatic int model_grant();
        if (!rst_n) return -1;
        if (!mode) return (int'(sel) < CH) ? int'(sel) : -1;
        for (int i = 0; i < CH; i++) begin
            if (in_valid[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
        end
        return -1;
    endfunction

    // Check at the falling edge, then advance the model across the rising edge
    task automatic cycle();
        int            g;
        logic          free;
        logic [CH-1:0] er;
        @(negedge clk);
        g    = model_grant();
        free = !m_vld || out_ready;
        er   = '0;
        if (free && g >= 0) er[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("out_data", 32'(out_data), 32'(m_dat));
        chk("out_chan", 32'(out_chan), 32'(m_chan));
        @(posedge clk);
        if (!rst_n) begin
            m_vld = 1'b0; m_dat = '0; m_chan = '0; m_ptr = 0;
        end else if (g >= 0 && in_valid[g] && free) begin
            m_vld  = 1'b1;
            m_dat  = in_data[g*W +: W];
            m_chan = SW'(g);
            if (mode) m_ptr = (g + 1) % CH;
        end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [SW-1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n = 1'b0; in_valid = '1; in_data = {4'h4, 4'h3, 4'h2, 4'h1};
        mode = 1'b0; sel = '0; out_ready = 1'b1;
        @(posedge clk);
        m_vld = 1'b0; m_dat = '0; m_chan = '0; m_ptr = 0;
        #1;

        // Reset with every channel requesting
        cycle(); cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);

        // Fixed select of channel 2
        rst_n = 1'b1; sel = 2'd2; in_data = {4'h4, 4'hA, 4'h2, 4'h1};
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        cycle();
        chk("fix_out_data", 32'(out_data), 32'hA);
        chk("fix_out_chan", 32'(out_chan), 32'd2);
        chk("fix_out_valid", 32'(out_valid), 32'd1);

        // Backpressure on a held beat, then pop and load together
        in_data = {4'h4, 4'h5, 4'h2, 4'h1};
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_out_data", 32'(out_data), 32'h5);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_data = {4'h4, 4'h6, 4'h2, 4'h1}; out_ready = 1'b1;
        #1;
        chk("popload_in_ready", 32'(in_ready), 32'b0100);
        cycle();
        chk("popload_out_data", 32'(out_data), 32'h6);
        chk("popload_out_valid", 32'(out_valid), 32'd1);

        // Round robin with all channels valid
        mode = 1'b1; in_valid = 4'b1111; in_data = {4'h4, 4'h3, 4'h2, 4'h1};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_chan", 32'(out_chan), 32'(rr_seq[i]));
            chk("rr_data", 32'(out_data), 32'(rr_seq[i]) + 32'd1);
        end

        // Move pointer to 3, then skip idle channel 3 and wrap
        in_valid = 4'b0100;
        cycle();
        chk("ptr3_chan", 32'(out_chan), 32'd2);
        in_valid = 4'b0011;
        cycle(); chk("skip_chan0", 32'(out_chan), 32'd0);
        cycle(); chk("skip_chan1", 32'(out_chan), 32'd1);
        cycle(); chk("skip_chan0b", 32'(out_chan), 32'd0);

        // Reset while a beat is stalled; pointer must restart at 0
        in_valid = 4'b0100;
        cycle();
        out_ready = 1'b0; in_valid = 4'b0000;
        cycle();
        chk("midrst_held", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1010;
        cycle();
        chk("midrst_first_chan", 32'(out_chan), 32'd1);
        chk("midrst_first_data", 32'(out_data), 32'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            in_data   = 16'($urandom);
            in_valid  = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
